// File: rtl/text_pkg.sv
// Shared constants and FSM state type for the character screen buffer.
package text_pkg;

    localparam logic [7:0] CHAR_BS   = 8'h08;
    localparam logic [7:0] CHAR_LF   = 8'h0A;
    localparam logic [7:0] CHAR_FF   = 8'h0C;
    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] BLANK     = 8'h20;
    localparam logic [7:0] PRINT_MIN = 8'h20;
    localparam logic [7:0] PRINT_MAX = 8'h7E;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_e;

endpackage

// File: rtl/text_ram.sv
// Simple dual-port character RAM: one write port, one read port with enable.
// A read and write to the same address in one cycle return the old contents.
module text_ram
    import text_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 reset_low,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [7:0]           wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [7:0]           rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [7:0] mem [DEPTH];

    // Array has no reset; CLEAR in the controller initialises visible cells.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            rdata <= BLANK;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/text_buffer.sv
// Character screen memory: stores a byte stream at a hardware cursor and serves
// character codes to the glyph ROM on timing-generator block strobes.
module text_buffer
    import text_pkg::*;
#(
    parameter int unsigned COLS     = 80,
    parameter int unsigned ROWS     = 24,
    parameter int unsigned COL_BITS = 7,
    parameter int unsigned ROW_BITS = 5
) (
    input  logic                clk,
    input  logic                reset_low,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    input  logic                rd_ce,
    input  logic [COL_BITS-1:0] rd_col,
    input  logic [ROW_BITS-1:0] rd_row,
    output logic [7:0]          rd_char,
    output logic [COL_BITS-1:0] cursor_col,
    output logic [ROW_BITS-1:0] cursor_row,
    output logic                busy
);

    localparam int unsigned ADDR_BITS = ROW_BITS + COL_BITS;
    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);
    localparam logic [COL_BITS-1:0] COL_ONE  = COL_BITS'(1);
    localparam logic [ROW_BITS-1:0] ROW_ONE  = ROW_BITS'(1);

    state_e              state_q, state_d;
    logic [COL_BITS-1:0] cur_col_q, cur_col_d, clr_col_q, clr_col_d;
    logic [ROW_BITS-1:0] cur_row_q, cur_row_d, clr_row_q, clr_row_d;
    logic                ram_we;
    logic [ADDR_BITS-1:0] ram_waddr;
    logic [7:0]          ram_wdata;
    logic [ROW_BITS-1:0] next_row;

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q == CLEAR);
    assign cursor_col = cur_col_q;
    assign cursor_row = cur_row_q;
    assign next_row   = (cur_row_q == LAST_ROW) ? '0 : cur_row_q + ROW_ONE;

    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            state_q   <= CLEAR;
            cur_col_q <= '0;
            cur_row_q <= '0;
            clr_col_q <= '0;
            clr_row_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_col_q <= cur_col_d;
            cur_row_q <= cur_row_d;
            clr_col_q <= clr_col_d;
            clr_row_q <= clr_row_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_col_d = cur_col_q;
        cur_row_d = cur_row_q;
        clr_col_d = clr_col_q;
        clr_row_d = clr_row_q;
        ram_we    = 1'b0;
        ram_waddr = {cur_row_q, cur_col_q};
        ram_wdata = in_data;
        case (state_q)
            CLEAR: begin
                // Row-major sweep over visible cells only.
                ram_we    = 1'b1;
                ram_waddr = {clr_row_q, clr_col_q};
                ram_wdata = BLANK;
                if (clr_col_q == LAST_COL) begin
                    clr_col_d = '0;
                    if (clr_row_q == LAST_ROW) begin
                        clr_row_d = '0;
                        state_d   = IDLE;
                        cur_col_d = '0;
                        cur_row_d = '0;
                    end else begin
                        clr_row_d = clr_row_q + ROW_ONE;
                    end
                end else begin
                    clr_col_d = clr_col_q + COL_ONE;
                end
            end
            IDLE: begin
                if (in_valid) begin
                    if (in_data >= PRINT_MIN && in_data <= PRINT_MAX) begin
                        ram_we = 1'b1;
                        if (cur_col_q == LAST_COL) begin
                            cur_col_d = '0;
                            cur_row_d = next_row;
                        end else begin
                            cur_col_d = cur_col_q + COL_ONE;
                        end
                    end else begin
                        case (in_data)
                            CHAR_CR: cur_col_d = '0;
                            CHAR_LF: cur_row_d = next_row;
                            CHAR_BS: begin
                                if (cur_col_q != '0) begin
                                    cur_col_d = cur_col_q - COL_ONE;
                                end
                            end
                            CHAR_FF: begin
                                state_d   = CLEAR;
                                clr_col_d = '0;
                                clr_row_d = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

    text_ram #(
        .ADDR_BITS(ADDR_BITS)
    ) u_ram (
        .clk      (clk),
        .reset_low(reset_low),
        .we       (ram_we),
        .waddr    (ram_waddr),
        .wdata    (ram_wdata),
        .re       (rd_ce),
        .raddr    ({rd_row, rd_col}),
        .rdata    (rd_char)
    );

endmodule

// File: tb/tb_text_buffer.sv
// Self-checking bench for text_buffer: directed vectors, corner sequences and
// random byte streams checked against a 2-D screen model.
module tb_text_buffer;

    localparam int COLS = 80;
    localparam int ROWS = 24;
    localparam int CELLS = COLS * ROWS;

    logic       clk = 1'b0;
    logic       reset_low;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       rd_ce;
    logic [6:0] rd_col;
    logic [4:0] rd_row;
    logic [7:0] rd_char;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;
    logic       busy;

    int passed = 0;
    int total  = 0;

    logic [7:0] scr [ROWS][COLS];
    int mr, mc;

    always #5 clk = ~clk;

    text_buffer dut (
        .clk       (clk),
        .reset_low (reset_low),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .rd_ce     (rd_ce),
        .rd_col    (rd_col),
        .rd_row    (rd_row),
        .rd_char   (rd_char),
        .cursor_col(cursor_col),
        .cursor_row(cursor_row),
        .busy      (busy)
    );

    typedef struct {
        logic [7:0] data;
        int         col;
        int         row;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    function automatic void model_clear();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                scr[r][c] = 8'h20;
            end
        end
        mr = 0;
        mc = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            scr[mr][mc] = b;
            if (mc == COLS - 1) begin
                mc = 0;
                mr = (mr + 1) % ROWS;
            end else begin
                mc++;
            end
        end else if (b == 8'h0D) begin
            mc = 0;
        end else if (b == 8'h0A) begin
            mr = (mr + 1) % ROWS;
        end else if (b == 8'h08) begin
            if (mc > 0) mc--;
        end else if (b == 8'h0C) begin
            model_clear();
        end
    endfunction

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_byte(b);
    endtask

    task automatic rd(input int r, input int c, output logic [7:0] v);
        rd_ce  = 1'b1;
        rd_row = r[4:0];
        rd_col = c[6:0];
        @(posedge clk);
        #1;
        rd_ce = 1'b0;
        v = rd_char;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!in_ready && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic chk_cursor(input string name);
        chk({name, " col"}, 32'(cursor_col), 32'(mc));
        chk({name, " row"}, 32'(cursor_row), 32'(mr));
    endtask

    task automatic readback_all(input string name);
        logic [7:0] v;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                rd(r, c, v);
                chk(name, 32'(v), 32'(scr[r][c]));
            end
        end
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] b;
        int n;

        vecs[0]  = '{8'h41, 1, 0};
        vecs[1]  = '{8'h42, 2, 0};
        vecs[2]  = '{8'h0D, 0, 0};
        vecs[3]  = '{8'h0A, 0, 1};
        vecs[4]  = '{8'h08, 0, 1};
        vecs[5]  = '{8'h43, 1, 1};
        vecs[6]  = '{8'h08, 0, 1};
        vecs[7]  = '{8'h07, 0, 1};
        vecs[8]  = '{8'h7E, 1, 1};
        vecs[9]  = '{8'h7F, 1, 1};
        vecs[10] = '{8'h1F, 1, 1};
        vecs[11] = '{8'h00, 1, 1};

        reset_low = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        rd_ce     = 1'b0;
        rd_col    = '0;
        rd_row    = '0;
        model_clear();

        // Reset state
        #23;
        chk("reset rd_char", 32'(rd_char), 32'h20);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        chk("reset busy", 32'(busy), 32'd1);
        chk_cursor("reset cursor");

        @(posedge clk);
        #1;
        reset_low = 1'b1;
        wait_ready(n);
        chk("init clear cycles", 32'(n), 32'(CELLS));
        chk("idle busy", 32'(busy), 32'd0);
        rd(23, 79, v);
        chk("blank (23,79)", 32'(v), 32'h20);

        // Directed cursor vectors
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].data);
            chk("vec col", 32'(cursor_col), 32'(vecs[i].col));
            chk("vec row", 32'(cursor_row), 32'(vecs[i].row));
        end
        rd(0, 0, v);
        chk("read (0,0)", 32'(v), 32'h41);
        rd_row = 5'd3;
        rd_col = 7'd3;
        @(posedge clk);
        #1;
        chk("hold rd_char", 32'(rd_char), 32'h41);
        rd(0, 1, v);
        chk("read (0,1)", 32'(v), 32'h42);
        rd(1, 0, v);
        chk("read (1,0)", 32'(v), 32'h7E);

        // Wrap at the last cell, LF at the last row, CR and BS at col 0
        send(8'h0D);
        for (int i = 0; i < 22; i++) send(8'h0A);
        for (int i = 0; i < 79; i++) send(8'h78);
        chk("pre-wrap col", 32'(cursor_col), 32'd79);
        chk("pre-wrap row", 32'(cursor_row), 32'd23);
        send(8'h42);
        chk("wrap col", 32'(cursor_col), 32'd0);
        chk("wrap row", 32'(cursor_row), 32'd0);
        rd(23, 79, v);
        chk("read (23,79)", 32'(v), 32'h42);
        for (int i = 0; i < 23; i++) send(8'h0A);
        send(8'h0A);
        chk("lf wrap row", 32'(cursor_row), 32'd0);
        send(8'h61);
        send(8'h0D);
        chk("cr col", 32'(cursor_col), 32'd0);
        send(8'h08);
        chk("bs sat col", 32'(cursor_col), 32'd0);

        // Same-cycle read and write of (0,5)
        for (int i = 0; i < 5; i++) send(8'h2E);
        in_valid = 1'b1;
        in_data  = 8'h43;
        rd_ce    = 1'b1;
        rd_row   = 5'd0;
        rd_col   = 7'd5;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rd_ce    = 1'b0;
        model_byte(8'h43);
        chk("rw old data", 32'(rd_char), 32'h20);
        rd(0, 5, v);
        chk("rw new data", 32'(v), 32'h43);
        chk_cursor("rw cursor");

        // Random byte stream against the model
        for (int i = 0; i < 400; i++) begin
            n = int'($urandom_range(0, 99));
            if (n < 70) b = 8'($urandom_range(32, 126));
            else if (n < 78) b = 8'h0D;
            else if (n < 86) b = 8'h0A;
            else if (n < 94) b = 8'h08;
            else begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h0C) b = 8'h07;
            end
            if ($urandom_range(0, 3) == 0) begin
                in_data = b;
                @(posedge clk);
                #1;
            end else begin
                send(b);
            end
            chk_cursor("rand cursor");
        end
        readback_all("rand cell");

        // Form feed: bytes offered during CLEAR are not consumed
        in_valid = 1'b1;
        in_data  = 8'h0C;
        @(posedge clk);
        #1;
        model_byte(8'h0C);
        in_data = 8'h41;
        chk("ff in_ready", 32'(in_ready), 32'd0);
        chk("ff busy", 32'(busy), 32'd1);
        wait_ready(n);
        in_valid = 1'b0;
        chk("ff clear cycles", 32'(n), 32'(CELLS));
        chk_cursor("ff cursor");
        readback_all("ff cell");

        // Reset in the middle of CLEAR
        send(8'h51);
        rd(0, 0, v);
        chk("pre-reset read", 32'(v), 32'h51);
        send(8'h0C);
        repeat (500) @(posedge clk);
        #2;
        reset_low = 1'b0;
        #1;
        chk("async rd_char", 32'(rd_char), 32'h20);
        chk("async in_ready", 32'(in_ready), 32'd0);
        chk("async busy", 32'(busy), 32'd1);
        chk("async col", 32'(cursor_col), 32'd0);
        chk("async row", 32'(cursor_row), 32'd0);
        @(posedge clk);
        #1;
        reset_low = 1'b1;
        model_clear();
        wait_ready(n);
        chk("rst clear cycles", 32'(n), 32'(CELLS));
        send(8'h07);
        chk_cursor("bell cursor");
        rd(0, 0, v);
        chk("bell no write", 32'(v), 32'h20);
        rd(23, 79, v);
        chk("post-rst (23,79)", 32'(v), 32'h20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
